// File: rtl/pipeline_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding, register-zero constant and operand match helper for pipeline_ctrl.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    function automatic logic match(
        input logic [4:0] r,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return (r != REG_ZERO) && ((r == rs1) || (uses_rs2 && (r == rs2)));
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: pipeline-status inputs and stage-register controls between the datapath and pipeline_ctrl.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic             id_branch_taken;
    logic             id_ecall;
    logic [4:0]       ex_rd;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic [4:0]       mem_rd;
    logic             mem_reg_write;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_enable;
    logic             if_id_enable;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_mem_enable;
    logic             mem_wb_enable;
    logic             halted;
    logic             mem_error;
    logic [CNT_W-1:0] stall_cycles;

    // Datapath side: reports stage status, consumes register controls.
    modport master (
        output id_rs1, id_rs2, id_uses_rs2, id_branch_taken, id_ecall,
        output ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
        output dmem_req, dmem_ready,
        input  pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
        input  ex_mem_enable, mem_wb_enable, halted, mem_error, stall_cycles
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, id_branch_taken, id_ecall,
        input  ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_reg_write,
        input  dmem_req, dmem_ready,
        output pc_enable, if_id_enable, if_id_flush, id_ex_bubble,
        output ex_mem_enable, mem_wb_enable, halted, mem_error, stall_cycles
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: RAW hazard on ID operands; PIPE_CTRL_FORWARD_EN reduces it to load-use only.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic       ex_mem_read,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    output logic       hazard
);

`ifdef PIPE_CTRL_FORWARD_EN
    // EX/MEM results are forwarded, so only a load in EX cannot be bypassed in time.
    logic unused_ports;
    assign unused_ports = ex_reg_write ^ mem_reg_write ^ (^mem_rd);
    assign hazard = ex_mem_read && match(ex_rd, id_rs1, id_rs2, id_uses_rs2);
`else
    // No forwarding: wait for EX and MEM writers; WB is covered by the write-through register file.
    logic unused_ports;
    assign unused_ports = ex_mem_read;
    assign hazard = (ex_reg_write && match(ex_rd, id_rs1, id_rs2, id_uses_rs2)) ||
                    (mem_reg_write && match(mem_rd, id_rs1, id_rs2, id_uses_rs2));
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/halt sequencer for the 5-stage pipeline; optional forwarding via PIPE_CTRL_FORWARD_EN.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int MEM_TIMEOUT  = 64
) (
    input logic           clock,
    input logic           reset,
    pipeline_ctrl_if.slave bus
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    state_t           state;
    state_t           state_nx;
    logic [DW-1:0]    drain_cnt;
    logic [DW-1:0]    drain_nx;
    logic [WW-1:0]    wait_cnt;
    logic [WW-1:0]    wait_nx;
    logic             mem_error;
    logic             error_nx;
    logic [CNT_W-1:0] stall_cycles;
    logic             hazard;
    logic             freeze;
    logic             pc_en;
    logic             if_id_en;
    logic             flush;
    logic             bubble;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             halt;

    hazard_detect u_hazard (
        .id_rs1        (bus.id_rs1),
        .id_rs2        (bus.id_rs2),
        .id_uses_rs2   (bus.id_uses_rs2),
        .ex_rd         (bus.ex_rd),
        .ex_reg_write  (bus.ex_reg_write),
        .ex_mem_read   (bus.ex_mem_read),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_reg_write),
        .hazard        (hazard)
    );

    // Next-state, watchdog and stage controls; freeze beats hazard beats ecall beats branch.
    always_comb begin
        pc_en     = 1'b0;
        if_id_en  = 1'b0;
        flush     = 1'b0;
        bubble    = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        halt      = 1'b0;
        state_nx  = state;
        drain_nx  = drain_cnt;
        wait_nx   = '0;
        error_nx  = mem_error;
        freeze    = (state != HALTED) && bus.dmem_req && !bus.dmem_ready;
        if (freeze) begin
            wait_nx = wait_cnt + WW'(1);
            if (wait_cnt == WW'(MEM_TIMEOUT - 1)) begin
                state_nx = HALTED;
                error_nx = 1'b1;
            end
        end
        case (state)
            RUN: begin
                if (!freeze) begin
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    if (hazard || bus.id_ecall) begin
                        bubble = 1'b1;
                        if (!hazard) begin
                            state_nx = DRAIN;
                            drain_nx = '0;
                        end
                    end else begin
                        pc_en    = 1'b1;
                        if_id_en = 1'b1;
                        flush    = bus.id_branch_taken;
                    end
                end
            end
            DRAIN: begin
                if (!freeze) begin
                    bubble    = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                    drain_nx  = drain_cnt + DW'(1);
                    if (drain_cnt == DW'(DRAIN_CYCLES - 1)) state_nx = HALTED;
                end
            end
            default: halt = 1'b1;
        endcase
        if (reset) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            flush     = 1'b0;
            bubble    = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            halt      = 1'b0;
        end
    end

    // State, counters and sticky error; stall count only advances in RUN and saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= RUN;
            drain_cnt    <= '0;
            wait_cnt     <= '0;
            mem_error    <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state     <= state_nx;
            drain_cnt <= drain_nx;
            wait_cnt  <= wait_nx;
            mem_error <= error_nx;
            if (state == RUN && !pc_en && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    assign bus.pc_enable     = pc_en;
    assign bus.if_id_enable  = if_id_en;
    assign bus.if_id_flush   = flush;
    assign bus.id_ex_bubble  = bubble;
    assign bus.ex_mem_enable = ex_mem_en;
    assign bus.mem_wb_enable = mem_wb_en;
    assign bus.halted        = halt;
    assign bus.mem_error     = mem_error;
    assign bus.stall_cycles  = stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed scoreboard bench for pipeline_ctrl (narrow stall counter to reach saturation).
module tb_pipeline_ctrl;

    localparam int CNT_W = 3;
    localparam int SAT   = 7;

    // Control vector order: pc, if_id_en, flush, bubble, ex_mem_en, mem_wb_en, halted, mem_error.
    localparam logic [7:0] NORMAL   = 8'b1100_1100;
    localparam logic [7:0] STALL    = 8'b0001_1100;
    localparam logic [7:0] BRANCH   = 8'b1110_1100;
    localparam logic [7:0] FROZEN   = 8'b0000_0000;
    localparam logic [7:0] HALT     = 8'b0000_0010;
    localparam logic [7:0] HALT_ERR = 8'b0000_0011;
    localparam logic [7:0] ERR_ONLY = 8'b0000_0001;
`ifdef PIPE_CTRL_FORWARD_EN
    localparam logic [7:0] MEM_RAW  = NORMAL;
`else
    localparam logic [7:0] MEM_RAW  = STALL;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(
        .CNT_W        (CNT_W),
        .DRAIN_CYCLES (3),
        .MEM_TIMEOUT  (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;
    int exp_st = 0;

    string      tag_q[$];
    logic [7:0] ctl_q[$];
    int         st_q[$];

    wire [7:0] obs = {bus.pc_enable, bus.if_id_enable, bus.if_id_flush, bus.id_ex_bubble,
                      bus.ex_mem_enable, bus.mem_wb_enable, bus.halted, bus.mem_error};

    task automatic clear_inputs();
        bus.id_rs1 = 5'd0;
        bus.id_rs2 = 5'd0;
        bus.id_uses_rs2 = 1'b0;
        bus.id_branch_taken = 1'b0;
        bus.id_ecall = 1'b0;
        bus.ex_rd = 5'd0;
        bus.ex_reg_write = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.mem_rd = 5'd0;
        bus.mem_reg_write = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_ready = 1'b0;
    endtask

    // Push the expectation for the inputs just driven, compare once outputs settle, then advance one cycle.
    task automatic step(input string tag, input logic [7:0] ctl, input bit run);
        string      t;
        logic [7:0] c;
        int         s;
        tag_q.push_back(tag);
        ctl_q.push_back(ctl);
        st_q.push_back(exp_st);
        #1;
        t = tag_q.pop_front();
        c = ctl_q.pop_front();
        s = st_q.pop_front();
        total++;
        assert (obs === c) passed++;
        else $error("FAIL %s ctl: observed %b expected %b", t, obs, c);
        total++;
        assert (bus.stall_cycles === CNT_W'(s)) passed++;
        else $error("FAIL %s stall_cycles: observed %0d expected %0d", t, bus.stall_cycles, s);
        if (run && !ctl[7] && exp_st < SAT) exp_st++;
        @(negedge clock);
    endtask

    task automatic set_hazard(input logic [4:0] rd);
        bus.ex_rd = rd;
        bus.ex_reg_write = 1'b1;
        bus.ex_mem_read = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clock);
        step("reset", FROZEN, 1'b0);
        reset = 1'b0;
        step("normal", NORMAL, 1'b1);

        bus.id_rs1 = 5'd5;
        set_hazard(5'd5);
        step("ex_raw", STALL, 1'b1);
        bus.ex_reg_write = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.mem_rd = 5'd5;
        bus.mem_reg_write = 1'b1;
        step("mem_raw", MEM_RAW, 1'b1);
        bus.mem_reg_write = 1'b0;
        step("raw_clear", NORMAL, 1'b1);

        bus.id_rs1 = 5'd0;
        set_hazard(5'd0);
        step("x0", NORMAL, 1'b1);
        bus.id_rs1 = 5'd1;
        bus.id_rs2 = 5'd7;
        set_hazard(5'd7);
        step("rs2_unused", NORMAL, 1'b1);
        bus.id_uses_rs2 = 1'b1;
        step("rs2_raw", STALL, 1'b1);
        clear_inputs();

        bus.id_rs1 = 5'd5;
        bus.id_branch_taken = 1'b1;
        set_hazard(5'd5);
        step("br_hazard", STALL, 1'b1);
        bus.ex_reg_write = 1'b0;
        bus.ex_mem_read = 1'b0;
        step("br_go", BRANCH, 1'b1);
        clear_inputs();

        bus.dmem_req = 1'b1;
        step("freeze1", FROZEN, 1'b1);
        bus.id_rs1 = 5'd5;
        set_hazard(5'd5);
        step("freeze2", FROZEN, 1'b1);
        clear_inputs();
        bus.dmem_req = 1'b1;
        bus.id_ecall = 1'b1;
        step("freeze3", FROZEN, 1'b1);
        bus.id_ecall = 1'b0;
        bus.dmem_ready = 1'b1;
        step("freeze_done", NORMAL, 1'b1);
        clear_inputs();
        step("after_freeze", NORMAL, 1'b1);

        bus.dmem_req = 1'b1;
        step("wd1", FROZEN, 1'b1);
        step("wd2", FROZEN, 1'b1);
        step("wd3", FROZEN, 1'b1);
        step("wd4", FROZEN, 1'b1);
        step("wd_halt", HALT_ERR, 1'b0);
        bus.dmem_ready = 1'b1;
        step("wd_ready", HALT_ERR, 1'b0);
        clear_inputs();
        step("wd_stuck", HALT_ERR, 1'b0);
        reset = 1'b1;
        step("rst_in_halt", ERR_ONLY, 1'b0);
        exp_st = 0;
        step("rst_hold", FROZEN, 1'b0);
        reset = 1'b0;
        step("wd_recover", NORMAL, 1'b1);

        bus.id_ecall = 1'b1;
        step("ecall", STALL, 1'b1);
        bus.id_ecall = 1'b0;
        step("drain0", STALL, 1'b0);
        bus.id_branch_taken = 1'b1;
        step("drain1", STALL, 1'b0);
        bus.id_branch_taken = 1'b0;
        step("drain2", STALL, 1'b0);
        step("ecall_halt", HALT, 1'b0);
        step("ecall_stay", HALT, 1'b0);
        reset = 1'b1;
        step("rst_halted", FROZEN, 1'b0);
        exp_st = 0;
        reset = 1'b0;
        step("post_halt", NORMAL, 1'b1);

        bus.id_ecall = 1'b1;
        step("ecall2", STALL, 1'b1);
        bus.id_ecall = 1'b0;
        step("drain0_b", STALL, 1'b0);
        reset = 1'b1;
        step("rst_drain", FROZEN, 1'b0);
        exp_st = 0;
        reset = 1'b0;
        step("run_a", NORMAL, 1'b1);
        step("run_b", NORMAL, 1'b1);
        step("run_c", NORMAL, 1'b1);
        step("run_d", NORMAL, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
